// File: rtl/fixed_point_pkg.sv
// Shared definitions for the keypad decimal entry encoder: operand word layout,
// key codes, divider sizing and the entry FSM state encoding.
package fixed_point_pkg;

  // Operand word layout: [15]=sign, [14:6]=integer magnitude, [5:0]=fraction in 1/64.
  localparam int INT_BITS  = 9;
  localparam int FRAC_BITS = 6;
  localparam int WORD_W    = 1 + INT_BITS + FRAC_BITS;

  // Fraction divider sizing: numerator f*64+50 (f <= 99) fits 13 bits, divisor is 100.
  localparam int              NUM_W      = 13;
  localparam int              DIV_W      = 7;
  localparam int              Q_W        = FRAC_BITS;
  localparam logic [DIV_W-1:0] DIVISOR    = 7'd100;
  localparam logic [NUM_W-1:0] ROUND_BIAS = 13'd50;
  localparam logic [3:0]       ITER_CNT   = 4'd13;

  // Keypad codes; 0-9 are digits, E/F are ignored.
  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
  localparam logic [3:0] KEY_MINUS     = 4'hA;
  localparam logic [3:0] KEY_POINT     = 4'hB;
  localparam logic [3:0] KEY_CLEAR     = 4'hC;
  localparam logic [3:0] KEY_ENTER     = 4'hD;

  typedef enum logic [1:0] {
    ST_INT  = 2'd0,
    ST_FRAC = 2'd1,
    ST_CONV = 2'd2,
    ST_HOLD = 2'd3
  } entry_state_e;

  // Two BCD digits to binary using x10 = x8 + x2 shift-add.
  function automatic logic [6:0] bcd2_to_bin(input logic [3:0] tens, input logic [3:0] units);
    bcd2_to_bin = {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, units};
  endfunction

endpackage

// File: rtl/frac_divider.sv
// Restoring divider producing floor(dividend / 100), one quotient bit per clock.
// Only the low Q_W quotient bits are kept; the numerator range guarantees the
// discarded upper quotient bits are zero.
module frac_divider
  import fixed_point_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [NUM_W-1:0] dividend_i,
  output logic [Q_W-1:0]   quotient_o,
  output logic             done_o
);

  logic [NUM_W-1:0] shift_q;
  logic [DIV_W-1:0] rem_q;
  logic [Q_W-1:0]   quot_q;
  logic [3:0]       cnt_q;
  logic             run_q;
  logic             done_q;

  logic [DIV_W:0]   trial_d;
  logic [DIV_W-1:0] diff_d;
  logic             ge_d;

  // One restoring step: bring down the next numerator bit and try subtracting 100.
  always_comb begin
    trial_d = {rem_q, shift_q[NUM_W-1]};
    ge_d    = (trial_d >= {1'b0, DIVISOR});
    if (ge_d) begin
      diff_d = trial_d[DIV_W-1:0] - DIVISOR;
    end else begin
      diff_d = trial_d[DIV_W-1:0];
    end
  end

  // Iteration sequencing; done pulses for one cycle on the edge of the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= {NUM_W{1'b0}};
      rem_q   <= {DIV_W{1'b0}};
      quot_q  <= {Q_W{1'b0}};
      cnt_q   <= 4'd0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (start_i) begin
      shift_q <= dividend_i;
      rem_q   <= {DIV_W{1'b0}};
      quot_q  <= {Q_W{1'b0}};
      cnt_q   <= ITER_CNT;
      run_q   <= 1'b1;
      done_q  <= 1'b0;
    end else if (run_q) begin
      shift_q <= {shift_q[NUM_W-2:0], 1'b0};
      rem_q   <= diff_d;
      quot_q  <= {quot_q[Q_W-2:0], ge_d};
      cnt_q   <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign quotient_o = quot_q;
  assign done_o     = done_q;

endmodule

// File: rtl/decimal_entry_to_fixed.sv
// Keypad-side encoder: captures sign, two integer and two fraction BCD digits,
// then converts them into the calculator's sign-magnitude fixed-point operand
// and holds the result until the consumer accepts it.
module decimal_entry_to_fixed #(
  parameter int INT_BITS  = fixed_point_pkg::INT_BITS,
  parameter int FRAC_BITS = fixed_point_pkg::FRAC_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        key_valid,
  input  logic [3:0]                  key_code,
  output logic                        busy,
  output logic                        entry_sign,
  output logic [15:0]                 entry_bcd,
  output logic [INT_BITS+FRAC_BITS:0] binary_out,
  output logic                        out_valid,
  input  logic                        out_ready
);

  import fixed_point_pkg::*;

  localparam int W = 1 + INT_BITS + FRAC_BITS;

  entry_state_e state_q;
  logic         busy_q;
  logic         sign_q;
  logic         out_valid_q;
  logic [3:0]   tens_q;
  logic [3:0]   units_q;
  logic [3:0]   tenths_q;
  logic [3:0]   hund_q;
  logic [1:0]   int_cnt_q;
  logic [1:0]   frac_cnt_q;
  logic [W-1:0] binary_q;

  logic             accept_key_d;
  logic             is_digit_d;
  logic             start_d;
  logic [6:0]       int_val_d;
  logic [6:0]       frac_val_d;
  logic [NUM_W-1:0] numer_d;
  logic             neg_d;
  logic [W-1:0]     word_d;

  logic [Q_W-1:0]   div_quot;
  logic             div_done;

  // Key qualification, BCD-to-binary of both digit pairs and result word assembly.
  always_comb begin
    accept_key_d = key_valid && ((state_q == ST_INT) || (state_q == ST_FRAC));
    is_digit_d   = (key_code <= KEY_MAX_DIGIT);
    start_d      = accept_key_d && (key_code == KEY_ENTER);
    int_val_d    = bcd2_to_bin(tens_q, units_q);
    frac_val_d   = bcd2_to_bin(tenths_q, hund_q);
    numer_d      = {frac_val_d, 6'b000000} + ROUND_BIAS;
    // A zero magnitude never carries a minus sign.
    neg_d        = sign_q && ((int_val_d != 7'd0) || (div_quot != {Q_W{1'b0}}));
    word_d       = {neg_d, INT_BITS'(int_val_d), FRAC_BITS'(div_quot)};
  end

  frac_divider u_frac_divider (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_d),
    .dividend_i (numer_d),
    .quotient_o (div_quot),
    .done_o     (div_done)
  );

  // Entry FSM: key capture, conversion sequencing, result hold and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INT;
      busy_q      <= 1'b0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      tens_q      <= 4'd0;
      units_q     <= 4'd0;
      tenths_q    <= 4'd0;
      hund_q      <= 4'd0;
      int_cnt_q   <= 2'd0;
      frac_cnt_q  <= 2'd0;
      binary_q    <= {W{1'b0}};
    end else begin
      case (state_q)
        ST_INT, ST_FRAC: begin
          if (accept_key_d) begin
            if (is_digit_d) begin
              if (state_q == ST_INT) begin
                // Digits beyond the second integer digit are dropped.
                if (int_cnt_q < 2'd2) begin
                  tens_q    <= units_q;
                  units_q   <= key_code;
                  int_cnt_q <= int_cnt_q + 2'd1;
                end
              end else if (frac_cnt_q == 2'd0) begin
                tenths_q   <= key_code;
                frac_cnt_q <= 2'd1;
              end else if (frac_cnt_q == 2'd1) begin
                hund_q     <= key_code;
                frac_cnt_q <= 2'd2;
              end
            end else begin
              case (key_code)
                KEY_MINUS: sign_q  <= ~sign_q;
                KEY_POINT: state_q <= ST_FRAC;
                KEY_CLEAR: begin
                  state_q    <= ST_INT;
                  sign_q     <= 1'b0;
                  tens_q     <= 4'd0;
                  units_q    <= 4'd0;
                  tenths_q   <= 4'd0;
                  hund_q     <= 4'd0;
                  int_cnt_q  <= 2'd0;
                  frac_cnt_q <= 2'd0;
                end
                KEY_ENTER: begin
                  state_q <= ST_CONV;
                  busy_q  <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        ST_CONV: begin
          if (div_done) begin
            binary_q    <= word_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_INT;
            sign_q      <= 1'b0;
            tens_q      <= 4'd0;
            units_q     <= 4'd0;
            tenths_q    <= 4'd0;
            hund_q      <= 4'd0;
            int_cnt_q   <= 2'd0;
            frac_cnt_q  <= 2'd0;
          end
        end
        default: begin
          state_q     <= ST_INT;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign entry_sign = sign_q;
  assign entry_bcd  = {tens_q, units_q, tenths_q, hund_q};
  assign binary_out = binary_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_decimal_entry_to_fixed.sv
// Scoreboard bench for decimal_entry_to_fixed: the stimulus process feeds key
// presses to a decimal-arithmetic reference model that queues expected words;
// a monitor process pops and compares whenever a result is presented.
module tb_decimal_entry_to_fixed;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        busy;
  logic        entry_sign;
  logic [15:0] entry_bcd;
  logic [15:0] binary_out;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  decimal_entry_to_fixed dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .busy       (busy),
    .entry_sign (entry_sign),
    .entry_bcd  (entry_bcd),
    .binary_out (binary_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  typedef struct {
    logic [15:0] word;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: never ready

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- reference model (decimal arithmetic) ----------------
  bit          m_sign;
  bit          m_infrac;
  int          m_icnt;
  int          m_fcnt;
  int          m_id[2];
  int          m_fd[2];
  bit          m_ovr_en = 1'b0;
  logic [15:0] m_ovr;

  task automatic model_clear();
    m_sign = 1'b0; m_infrac = 1'b0; m_icnt = 0; m_fcnt = 0;
    m_id[0] = 0; m_id[1] = 0; m_fd[0] = 0; m_fd[1] = 0;
  endtask

  function automatic int model_int();
    if (m_icnt == 0) return 0;
    if (m_icnt == 1) return m_id[0];
    return m_id[0] * 10 + m_id[1];
  endfunction

  function automatic logic [15:0] model_bcd();
    int t, u;
    t = (m_icnt == 2) ? m_id[0] : 0;
    u = (m_icnt == 2) ? m_id[1] : ((m_icnt == 1) ? m_id[0] : 0);
    return 16'(t * 4096 + u * 256 + m_fd[0] * 16 + m_fd[1]);
  endfunction

  task automatic model_key(input logic [3:0] c);
    int ival, f, frac, w;
    exp_t e;
    if (c <= 4'd9) begin
      if (!m_infrac) begin
        if (m_icnt < 2) begin m_id[m_icnt] = int'(c); m_icnt++; end
      end else if (m_fcnt < 2) begin
        m_fd[m_fcnt] = int'(c); m_fcnt++;
      end
    end else begin
      case (c)
        4'hA: m_sign = ~m_sign;
        4'hB: m_infrac = 1'b1;
        4'hC: model_clear();
        4'hD: begin
          ival = model_int();
          f    = m_fd[0] * 10 + m_fd[1];
          frac = (f * 64 + 50) / 100;
          w    = ival * 64 + frac;
          if (m_sign && (w != 0)) w = w + 32768;
          e.word = m_ovr_en ? m_ovr : 16'(w);
          e.cyc  = cyc;
          exp_q.push_back(e);
          model_clear();
        end
        default: ;
      endcase
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic press(input logic [3:0] c, input bit to_model);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'($urandom_range(0, 15));
    if (to_model) model_key(c);
  endtask

  task automatic keys(input string s);
    byte ch;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      if (ch >= 8'h41) press(4'(ch - 8'h37), 1'b1);
      else             press(4'(ch - 8'h30), 1'b1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || out_valid) && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 400), 32'd1);
  endtask

  task automatic check_entry(input string name);
    check({name, "_bcd"}, 32'(entry_bcd), 32'(model_bcd()));
    check({name, "_sign"}, 32'(entry_sign), 32'(m_sign));
  endtask

  task automatic enter_expect(input logic [15:0] w);
    m_ovr_en = 1'b1;
    m_ovr    = w;
    press(4'hD, 1'b1);
    m_ovr_en = 1'b0;
    wait_idle();
    check("cleared_bcd", 32'(entry_bcd), 32'h0);
    check("cleared_sign", 32'(entry_sign), 32'h0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, 32'(busy), 32'h0);
    check({name, "_sign"}, 32'(entry_sign), 32'h0);
    check({name, "_bcd"}, 32'(entry_bcd), 32'h0);
    check({name, "_binary"}, 32'(binary_out), 32'h0);
    check({name, "_valid"}, 32'(out_valid), 32'h0);
  endtask

  // ---------------- monitor / consumer ----------------
  initial begin
    exp_t cur;
    bit   prev_valid;
    bit   acc_pend;
    prev_valid = 1'b0;
    acc_pend   = 1'b0;
    cur.word   = 16'h0;
    cur.cyc    = 0;
    forever @(negedge clk) begin
      if (rst) begin
        prev_valid = 1'b0;
        acc_pend   = 1'b0;
      end else begin
        if (acc_pend) begin
          check("valid_drop", 32'(out_valid), 32'h0);
          acc_pend = 1'b0;
        end else if (out_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'(out_valid), 32'h0);
          end else begin
            cur = exp_q.pop_front();
            check("result_word", 32'(binary_out), 32'(cur.word));
            check("latency", 32'(cyc - cur.cyc), 32'd14);
          end
        end else if (out_valid) begin
          check("result_stable", 32'(binary_out), 32'(cur.word));
        end
        prev_valid = out_valid;
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = 1'b0;
        endcase
        if (out_valid && out_ready) acc_pend = 1'b1;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int n;
    int nk;
    int r;
    logic [3:0] c;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    out_ready = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Directed values
    keys("87B12");
    check_entry("entry_87_12");
    enter_expect(16'h15C8);
    keys("A87B5");
    check_entry("entry_m87_5");
    enter_expect(16'h95E0);
    keys("99B99");
    enter_expect(16'h18FF);
    keys("123");
    check("third_int_dropped", 32'(entry_bcd), 32'h1200);
    enter_expect(16'h0300);
    keys("5B3");
    check("tenths_only", 32'(entry_bcd), 32'h0530);
    enter_expect(16'h0153);
    keys("A");
    check("minus_echo", 32'(entry_sign), 32'h1);
    enter_expect(16'h0000);
    keys("A45C7");
    check_entry("after_clear");
    press(4'hD, 1'b1);
    wait_idle();
    keys("3B4B56E");
    check_entry("frac_extra");
    press(4'hD, 1'b1);
    wait_idle();

    // Backpressure: result held, keys ignored while busy
    ready_mode = 2;
    keys("87B12");
    press(4'hD, 1'b1);
    n = 0;
    while (!out_valid && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_timeout", 32'(n < 40), 32'd1);
    for (int i = 0; i < 10; i++) begin
      press(4'($urandom_range(0, 9)), 1'b0);
      check("bp_busy", 32'(busy), 32'h1);
      check("bp_bcd", 32'(entry_bcd), 32'h8712);
    end
    ready_mode = 0;
    wait_idle();

    // Reset in the middle of the conversion
    keys("87B12");
    press(4'hD, 1'b1);
    check("conv_busy", 32'(busy), 32'h1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_conv_rst");
    exp_q.delete();
    model_clear();
    rst = 1'b0;
    keys("87B12");
    enter_expect(16'h15C8);

    // Randomized entries with random consumer backpressure
    ready_mode = 1;
    for (int t = 0; t < 30; t++) begin
      nk = $urandom_range(0, 7);
      for (int k = 0; k < nk; k++) begin
        r = $urandom_range(0, 9);
        if (r < 6)       c = 4'($urandom_range(0, 9));
        else if (r == 6) c = 4'hA;
        else if (r == 7) c = 4'hB;
        else if (r == 8) c = ($urandom_range(0, 3) == 0) ? 4'hC : 4'hE;
        else             c = 4'hF;
        press(c, 1'b1);
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          key_code = 4'($urandom_range(0, 15));
        end
      end
      check_entry("rand_entry");
      press(4'hD, 1'b1);
      press(4'($urandom_range(0, 15)), 1'b0);
      press(4'($urandom_range(0, 15)), 1'b0);
      wait_idle();
      check("rand_cleared", 32'(entry_bcd), 32'h0);
    end

    ready_mode = 0;
    repeat (3) @(negedge clk);
    check("drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
